// File: rtl/game_pkg.sv
// Shared game constants and the player FSM state type, used by the player,
// enemy and collision logic.
package game_pkg;

    localparam int SCREEN_W = 640;
    localparam int SCREEN_H = 480;
    localparam int PLAYER_Y = 440;
    localparam int SPRITE_W = 50;

    typedef enum logic [1:0] {
        ALIVE     = 2'd0,
        HIT       = 2'd1,
        GAME_OVER = 2'd2
    } player_state_t;

endpackage

// File: rtl/game_tick.sv
// Free-running divider: tick is high for one clk each time the counter wraps.
// Used as a clock enable for slow game motion instead of a derived clock.
module game_tick #(
    parameter int DIV = 350000
) (
    input  logic clk,
    input  logic rst_n,
    output logic tick
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (cnt == LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

    assign tick = (cnt == LAST);

endmodule

// File: rtl/player_paddle.sv
// Player paddle: movement, lives, invulnerability blink, score and restart.
// Define PLAYER_WRAP_EN to make the paddle wrap at screen edges instead of clamping.
module player_paddle
    import game_pkg::*;
#(
    parameter int X_INIT       = 295,
    parameter int Y_POS        = PLAYER_Y,
    parameter int PADDLE_W     = SPRITE_W,
    parameter int X_MAX        = SCREEN_W,
    parameter int STEP         = 4,
    parameter int TICK_DIV     = 350000,
    parameter int LIVES        = 3,
    parameter int INVULN_TICKS = 32
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        btn_left,
    input  logic        btn_right,
    input  logic        btn_start,
    input  logic        collision,
    input  logic        enemy_escaped,
    output logic [15:0] x_paddle1,
    output logic [15:0] y_paddle1,
    output logic        player_on,
    output logic [1:0]  lives,
    output logic [7:0]  score,
    output logic        game_over
);

    localparam logic [15:0] X_LIM     = 16'(X_MAX - PADDLE_W);
    localparam logic [15:0] STEP_W    = 16'(STEP);
    localparam logic [15:0] X_RST     = 16'(X_INIT);
    localparam logic [1:0]  LIVES_RST = 2'(LIVES);
    // At least 3 bits so bit 2 exists for the blink pattern.
    localparam int IW = ($clog2(INVULN_TICKS + 1) > 3) ? $clog2(INVULN_TICKS + 1) : 3;
    localparam logic [IW-1:0] INV_LOAD = IW'(INVULN_TICKS);
    localparam logic [IW-1:0] INV_ONE  = IW'(1);

    // Synchronizer bit order: {left, right, start, collision, escaped}
    logic [4:0] meta_q, sync_q;
    logic [2:0] edge_q;
    logic [2:0] rise;
    logic       left_s, right_s, start_p, hit_p, esc_p;
    logic       tick;

    player_state_t state, state_nx;
    logic [15:0]   x_q, x_nx;
    logic [1:0]    lives_q, lives_nx;
    logic [7:0]    score_q, score_nx;
    logic          player_on_q, player_on_nx;
    logic          game_over_q, game_over_nx;
    logic [IW-1:0] inv_cnt, inv_nx, inv_dec;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= '0;
            sync_q <= '0;
            edge_q <= '0;
        end else begin
            meta_q <= {btn_left, btn_right, btn_start, collision, enemy_escaped};
            sync_q <= meta_q;
            edge_q <= sync_q[2:0];
        end
    end

    assign left_s  = sync_q[4];
    assign right_s = sync_q[3];
    assign rise    = sync_q[2:0] & ~edge_q;
    assign start_p = rise[2];
    assign hit_p   = rise[1];
    assign esc_p   = rise[0];

    game_tick #(.DIV(TICK_DIV)) u_tick (
        .clk   (clk),
        .rst_n (rst_n),
        .tick  (tick)
    );

    // Compare before add/subtract so 16-bit arithmetic never wraps.
    function automatic logic [15:0] move_x(input logic [15:0] x, input logic l, input logic r);
        move_x = x;
        if (l && !r) begin
            if (x < STEP_W) begin
`ifdef PLAYER_WRAP_EN
                move_x = X_LIM;
`else
                move_x = '0;
`endif
            end else begin
                move_x = x - STEP_W;
            end
        end else if (r && !l) begin
            if (x + STEP_W > X_LIM) begin
`ifdef PLAYER_WRAP_EN
                move_x = '0;
`else
                move_x = X_LIM;
`endif
            end else begin
                move_x = x + STEP_W;
            end
        end
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ALIVE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            ALIVE:     if (hit_p) state_nx = (lives_q <= 2'd1) ? GAME_OVER : HIT;
            HIT:       if (tick && inv_cnt <= INV_ONE) state_nx = ALIVE;
            GAME_OVER: if (start_p) state_nx = ALIVE;
            default:   state_nx = ALIVE;
        endcase
    end

    assign inv_dec = inv_cnt - INV_ONE;

    always_comb begin
        x_nx         = x_q;
        lives_nx     = lives_q;
        score_nx     = score_q;
        player_on_nx = player_on_q;
        game_over_nx = game_over_q;
        inv_nx       = inv_cnt;
        if (state != GAME_OVER && tick) begin
            x_nx = move_x(x_q, left_s, right_s);
        end
        case (state)
            ALIVE: begin
                if (hit_p) begin
                    if (lives_q <= 2'd1) begin
                        lives_nx     = '0;
                        player_on_nx = 1'b0;
                        game_over_nx = 1'b1;
                    end else begin
                        lives_nx = lives_q - 2'd1;
                        inv_nx   = INV_LOAD;
                    end
                end else if (esc_p && score_q != 8'hFF) begin
                    score_nx = score_q + 8'd1;
                end
            end
            HIT: begin
                if (esc_p && score_q != 8'hFF) begin
                    score_nx = score_q + 8'd1;
                end
                if (tick) begin
                    if (inv_cnt <= INV_ONE) begin
                        inv_nx       = '0;
                        player_on_nx = 1'b1;
                    end else begin
                        inv_nx       = inv_dec;
                        player_on_nx = ~inv_dec[2];
                    end
                end
            end
            GAME_OVER: begin
                if (start_p) begin
                    x_nx         = X_RST;
                    lives_nx     = LIVES_RST;
                    score_nx     = '0;
                    player_on_nx = 1'b1;
                    game_over_nx = 1'b0;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_q         <= X_RST;
            lives_q     <= LIVES_RST;
            score_q     <= '0;
            player_on_q <= 1'b1;
            game_over_q <= 1'b0;
            inv_cnt     <= '0;
        end else begin
            x_q         <= x_nx;
            lives_q     <= lives_nx;
            score_q     <= score_nx;
            player_on_q <= player_on_nx;
            game_over_q <= game_over_nx;
            inv_cnt     <= inv_nx;
        end
    end

    assign x_paddle1 = x_q;
    assign y_paddle1 = 16'(Y_POS);
    assign player_on = player_on_q;
    assign lives     = lives_q;
    assign score     = score_q;
    assign game_over = game_over_q;

endmodule

// File: tb/tb_player_paddle.sv
// Directed bench for player_paddle with TICK_DIV=4, STEP=4, INVULN_TICKS=8, LIVES=3.
// Build with PLAYER_WRAP_EN defined to exercise edge wrapping.
module tb_player_paddle;
    import game_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        btn_left = 1'b0;
    logic        btn_right = 1'b0;
    logic        btn_start = 1'b0;
    logic        collision = 1'b0;
    logic        enemy_escaped = 1'b0;
    logic [15:0] x_paddle1;
    logic [15:0] y_paddle1;
    logic        player_on;
    logic [1:0]  lives;
    logic [7:0]  score;
    logic        game_over;

    int vec_cnt = 0;
    int err_cnt = 0;
    logic [31:0] exp_q[$];

    player_paddle #(
        .TICK_DIV     (4),
        .STEP         (4),
        .INVULN_TICKS (8),
        .LIVES        (3)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .btn_left      (btn_left),
        .btn_right     (btn_right),
        .btn_start     (btn_start),
        .collision     (collision),
        .enemy_escaped (enemy_escaped),
        .x_paddle1     (x_paddle1),
        .y_paddle1     (y_paddle1),
        .player_on     (player_on),
        .lives         (lives),
        .score         (score),
        .game_over     (game_over)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Hand model of one movement tick: 590 = 640 - 50, step 4.
    function automatic logic [15:0] exp_move(input logic [15:0] x, input logic l, input logic r);
        if (l && !r) begin
`ifdef PLAYER_WRAP_EN
            if (x < 16'd4) return 16'd590;
`else
            if (x < 16'd4) return 16'd0;
`endif
            return x - 16'd4;
        end
        if (r && !l) begin
`ifdef PLAYER_WRAP_EN
            if (x + 16'd4 > 16'd590) return 16'd0;
`else
            if (x + 16'd4 > 16'd590) return 16'd590;
`endif
            return x + 16'd4;
        end
        return x;
    endfunction

    // Hold buttons, checking every observed position change against the model.
    task automatic track(input logic l, input logic r, input int max_cycles, input int max_changes);
        logic [15:0] prev;
        int changes;
        changes   = 0;
        btn_left  = l;
        btn_right = r;
        prev      = x_paddle1;
        for (int i = 0; i < max_cycles && changes < max_changes; i++) begin
            @(negedge clk);
            if (x_paddle1 !== prev) begin
                check("step", 32'(x_paddle1), 32'(exp_move(prev, l, r)));
                prev = x_paddle1;
                changes++;
            end
        end
        btn_left  = 1'b0;
        btn_right = 1'b0;
        cycles(4);
    endtask

    task automatic pulse(input logic c, input logic e, input logic s);
        collision     = c;
        enemy_escaped = e;
        btn_start     = s;
        cycles(2);
        collision     = 1'b0;
        enemy_escaped = 1'b0;
        btn_start     = 1'b0;
        cycles(2);
    endtask

    initial begin
        bit seen_off;

        // reset
        cycles(3);
        rst_n = 1'b1;
        cycles(1);
        check("rst_x", 32'(x_paddle1), 32'd295);
        check("rst_y", 32'(y_paddle1), 32'd440);
        check("rst_lives", 32'(lives), 32'd3);
        check("rst_score", 32'(score), 32'd0);
        check("rst_on", 32'(player_on), 32'd1);
        check("rst_go", 32'(game_over), 32'd0);
        check("rst_state", 32'(dut.state), 32'(ALIVE));

        // both buttons held: no movement
        btn_left  = 1'b1;
        btn_right = 1'b1;
        cycles(40);
        check("both_hold", 32'(x_paddle1), 32'd295);
        btn_left  = 1'b0;
        btn_right = 1'b0;
        cycles(4);

`ifdef PLAYER_WRAP_EN
        track(1'b0, 1'b1, 1000, 74);
        check("wrap_right_past_max", 32'(x_paddle1), 32'd0);
        track(1'b1, 1'b0, 40, 1);
        check("wrap_left_from_0", 32'(x_paddle1), 32'd590);
        track(1'b0, 1'b1, 40, 1);
        check("wrap_right_from_590", 32'(x_paddle1), 32'd0);
`else
        track(1'b0, 1'b1, 800, 1000);
        check("clamp_right", 32'(x_paddle1), 32'd590);
        track(1'b1, 1'b0, 800, 1000);
        check("clamp_left", 32'(x_paddle1), 32'd0);
`endif

        // score saturation
        for (int i = 1; i <= 260; i++) begin
            pulse(1'b0, 1'b1, 1'b0);
            exp_q.push_back((i > 255) ? 32'd255 : 32'(i));
            check("score", 32'(score), exp_q.pop_front());
        end

        // hit and invulnerability
        pulse(1'b1, 1'b0, 1'b0);
        check("hit1_lives", 32'(lives), 32'd2);
        check("hit1_state", 32'(dut.state), 32'(HIT));
        pulse(1'b1, 1'b0, 1'b0);
        check("hit_ignored", 32'(lives), 32'd2);
        seen_off = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (player_on === 1'b0) seen_off = 1'b1;
        end
        check("blink_seen", 32'(seen_off), 32'd1);
        check("invuln_end_on", 32'(player_on), 32'd1);
        check("invuln_end_state", 32'(dut.state), 32'(ALIVE));

        // down to game over
        pulse(1'b1, 1'b0, 1'b0);
        check("hit2_lives", 32'(lives), 32'd1);
        cycles(45);
        check("hit2_recover", 32'(dut.state), 32'(ALIVE));
        pulse(1'b1, 1'b0, 1'b0);
        check("go_lives", 32'(lives), 32'd0);
        check("go_flag", 32'(game_over), 32'd1);
        check("go_on", 32'(player_on), 32'd0);
        check("go_state", 32'(dut.state), 32'(GAME_OVER));
        track(1'b0, 1'b1, 40, 100);
        check("go_no_move", 32'(x_paddle1), 32'd0);
        pulse(1'b0, 1'b1, 1'b0);
        check("go_esc_ignored", 32'(score), 32'd255);
        pulse(1'b1, 1'b0, 1'b0);
        check("go_hit_ignored", 32'(lives), 32'd0);

        // restart
        pulse(1'b0, 1'b0, 1'b1);
        check("restart_x", 32'(x_paddle1), 32'd295);
        check("restart_lives", 32'(lives), 32'd3);
        check("restart_score", 32'(score), 32'd0);
        check("restart_go", 32'(game_over), 32'd0);
        check("restart_on", 32'(player_on), 32'd1);
        check("restart_state", 32'(dut.state), 32'(ALIVE));

        // simultaneous hit and escape: hit wins
        pulse(1'b0, 1'b1, 1'b0);
        pulse(1'b0, 1'b1, 1'b0);
        check("pre_sim_score", 32'(score), 32'd2);
        track(1'b0, 1'b1, 12, 2);
        check("pre_sim_x", 32'(x_paddle1), 32'd303);
        pulse(1'b1, 1'b1, 1'b0);
        check("sim_lives", 32'(lives), 32'd2);
        check("sim_score", 32'(score), 32'd2);
        check("sim_state", 32'(dut.state), 32'(HIT));

        // asynchronous reset in the middle of HIT
        #2 rst_n = 1'b0;
        #1;
        check("areset_x", 32'(x_paddle1), 32'd295);
        check("areset_lives", 32'(lives), 32'd3);
        check("areset_score", 32'(score), 32'd0);
        check("areset_on", 32'(player_on), 32'd1);
        check("areset_go", 32'(game_over), 32'd0);
        check("areset_state", 32'(dut.state), 32'(ALIVE));
        @(negedge clk);
        rst_n = 1'b1;
        cycles(4);
        check("post_reset_lives", 32'(lives), 32'd3);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
